// File: rtl/apb5_regfile_completer.sv
// APB5 completer backing NUM_REGS software registers, each with a user side-band word.
// Supports programmable wait states, PPROT access checks, byte strobes and error responses.
module apb5_regfile_completer #(
  parameter int           ADDR_WIDTH      = 32,
  parameter int           DATA_WIDTH      = 32,
  parameter int           NUM_REGS        = 16,
  parameter int           WAIT_STATES     = 0,
  parameter int           USER_REQ_WIDTH  = 32,
  parameter int           USER_DATA_WIDTH = 32,
  parameter int           USER_RESP_WIDTH = 32,
  parameter logic [255:0] PRIV_MASK       = '0,
  parameter logic [255:0] SECURE_MASK     = '0
) (
  input  logic                           pclk,
  input  logic                           preset,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [2:0]                     pprot,
  input  logic                           pselx,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic                           pwakeup,
  input  logic [USER_REQ_WIDTH-1:0]      pauser,
  input  logic [USER_DATA_WIDTH-1:0]     pwuser,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  output logic [USER_DATA_WIDTH-1:0]     pruser,
  output logic [USER_RESP_WIDTH-1:0]     pbuser,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic                           clk_req
);

  // Handshake: a transfer starts with a setup cycle (pselx=1, penable=0) seen in IDLE and
  // completes on the ACCESS cycle where pready=1; dropping pselx in ACCESS aborts it.
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int UMAX  = (USER_REQ_WIDTH > USER_RESP_WIDTH) ? USER_REQ_WIDTH : USER_RESP_WIDTH;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]      regs  [NUM_REGS];
  logic [USER_DATA_WIDTH-1:0] uregs [NUM_REGS];

  logic [ADDR_WIDTH-1:0]      idx;
  logic                       in_range;
  logic                       prot_err;
  logic                       err;
  logic                       commit;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic [USER_DATA_WIDTH-1:0] rd_user;
  logic [UMAX-1:0]            auser_ext;
  logic                       unused_bits;

  // Address decode, protection check and read mux in one pass over the register bank.
  always_comb begin
    idx      = paddr >> OFFS;
    in_range = 1'b0;
    prot_err = 1'b0;
    rd_data  = '0;
    rd_user  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == ADDR_WIDTH'(i)) begin
        in_range = 1'b1;
        prot_err = (PRIV_MASK[i] && !pprot[0]) || (SECURE_MASK[i] && pprot[1]);
        rd_data  = regs[i];
        rd_user  = uregs[i];
      end
    end
    err = !in_range || prot_err || (!pwrite && (pstrb != '0));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pready  = (state_q == ACCESS) && penable && (cnt_q == 4'(WAIT_STATES));
    unique case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!pselx || pready) begin
          state_d = IDLE;
        end else if (cnt_q < 4'(WAIT_STATES)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pselx is also required so that an abort coinciding with the final cycle never writes.
  assign commit = pready && pselx && pwrite && !err && (pstrb != '0);

  assign auser_ext   = UMAX'(pauser);
  assign unused_bits = ^{pprot[2], auser_ext};

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    pruser  = '0;
    pbuser  = '0;
    if (pready) begin
      pslverr = err;
      pbuser  = auser_ext[USER_RESP_WIDTH-1:0];
      if (!pwrite && !err) begin
        prdata = rd_data;
        pruser = rd_user;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]  <= '0;
        uregs[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx == ADDR_WIDTH'(i)) begin
            for (int b = 0; b < BYTES; b++) begin
              if (pstrb[b]) regs[i][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
            uregs[i] <= pwuser;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign clk_req = pwakeup | pselx | (state_q == ACCESS);

endmodule

// File: doc/apb5_regfile_completer.md
Name: apb5_regfile_completer

Overview:
- Parametrised APB5 (rev D signal set) completer that backs a bank of NUM_REGS software registers with programmable wait states.
- Adds per-register PPROT access checks, byte-strobe writes and error signalling.
- Stores PWUSER alongside each register, returns it on PRUSER, and echoes PAUSER on PBUSER.
- Sits behind an APB decoder as the standard control/status block for peripherals; register contents are exported flat to the owning logic.

Parameters:
ADDR_WIDTH, 32, width of paddr
DATA_WIDTH, 32, data width; legal values 8, 16, 32
NUM_REGS, 16, number of registers; 1..256
WAIT_STATES, 0, pready-low cycles inserted in each access phase; 0..15
USER_REQ_WIDTH, 32, pauser width
USER_DATA_WIDTH, 32, pwuser/pruser width
USER_RESP_WIDTH, 32, pbuser width
PRIV_MASK, 0, bit i set: register i requires pprot[0]=1
SECURE_MASK, 0, bit i set: register i requires pprot[1]=0

Ports:
pclk  in  1  clock
preset  in  1  synchronous, active-high reset
paddr  in  ADDR_WIDTH  byte address
pprot  in  3  protection
pselx  in  1  select
penable  in  1  access phase
pwrite  in  1  1=write, 0=read
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  byte strobes
pwakeup  in  1  wake request
pauser  in  USER_REQ_WIDTH  request user
pwuser  in  USER_DATA_WIDTH  write-data user
pready  out  1  transfer complete
prdata  out  DATA_WIDTH  read data
pslverr  out  1  error
pruser  out  USER_DATA_WIDTH  read-data user
pbuser  out  USER_RESP_WIDTH  response user
reg_q  out  NUM_REGS*DATA_WIDTH  register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
clk_req  out  1  request for the local clock to stay enabled

Behaviour:
- Decoding
  - Word index idx = paddr >> log2(DATA_WIDTH/8).
  - Low address bits below word alignment are ignored.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when pselx=1 and penable=0 (setup cycle). Wait counter cnt is cleared to 0 in the same cycle.
  - ACCESS: cnt increments while cnt<WAIT_STATES.
  - pready = (state==ACCESS) && penable && (cnt==WAIT_STATES). It is combinational from registered state.
  - WAIT_STATES=0 completes in the first access cycle.
  - ACCESS -> IDLE on the completion edge (pready=1).
  - ACCESS -> IDLE if pselx drops (protocol abort). No write occurs on abort.
  - Back-to-back transfers: the setup cycle of the next transfer is seen from IDLE on the cycle after completion.
- Error: pslverr=1 during the completion cycle when any of the following holds:
  - idx>=NUM_REGS;
  - PRIV_MASK[idx]=1 and pprot[0]=0;
  - SECURE_MASK[idx]=1 and pprot[1]=1;
  - a read with pstrb!=0.
- Read completion, no error:
  - prdata = reg[idx], pruser = ureg[idx].
- Read completion with error:
  - prdata = 0, pruser = 0.
- Write commit at the completion edge when there is no error:
  - For each byte b with pstrb[b]=1: reg[idx] byte b = pwdata byte b.
  - ureg[idx] = pwuser if pstrb!=0.
  - Erroring writes leave all state unchanged.
  - pstrb=0 writes complete OKAY and change nothing.
- pbuser = pauser on every completion cycle, zero-extended or truncated to USER_RESP_WIDTH.
- When pready=0: prdata, pslverr, pruser and pbuser are all 0.
- clk_req = pwakeup | pselx | (state==ACCESS).
- Reset, applied any cycle including mid-transfer:
  - state=IDLE, cnt=0, all reg and ureg = 0.
  - pready=0, prdata=0, pslverr=0, pruser=0, pbuser=0, reg_q=0.
  - An in-flight write is discarded.
- pauser, pwuser and pprot are sampled at the completion cycle. The master holds them stable for the whole transfer.

Test Plan:
- Write then read, WAIT_STATES=0, DATA_WIDTH=32:
  - Write paddr=0x8, pwdata=0xDEADBEEF, pstrb=0xF, pwuser=0x5 -> pready=1 in the first access cycle, pslverr=0.
  - Read 0x8 -> prdata=0xDEADBEEF, pruser=0x5.
  - reg_q[95:64]=0xDEADBEEF.
- Strobes: reg2=0xDEADBEEF; write pwdata=0x11223344, pstrb=0x5 -> read returns 0xDE22BE44.
- Wait states, WAIT_STATES=3:
  - pready is low for 3 access cycles, high on the 4th.
  - Transfer spans 5 cycles including setup.
  - pbuser equals pauser=0xA5 on the completion cycle only.
- Errors, NUM_REGS=4, PRIV_MASK=0x2:
  - Write paddr=0x10 -> pslverr=1.
  - Write reg1 with pprot=3'b000 -> pslverr=1 and reg1 unchanged.
  - Same write with pprot=3'b001 -> OKAY.
  - Read with pstrb=0x1 -> pslverr=1, prdata=0.
- Reset mid-transfer:
  - Assert preset during the 2nd wait cycle of a write to reg0 -> reg0 stays 0, all outputs are 0 the next cycle.
  - The next transfer completes normally.
- Wakeup: pwakeup=1 with pselx=0 -> clk_req=1, pready=0. clk_req drops one cycle after the last completion.
